snake_mover: RTL and testbench
==============================

Name: snake_mover

Overview:
- Game-logic stage directly downstream of the frame-timing/stage generator.
- Consumes the per-frame `isDrawing` gap and the 32-bit `stage` value; advances the snake exactly once per frame while in the play stage.
- Holds the snake body as a segment shift register; detects food, wall and self collisions.
- Exposes head position, length, game-over and a registered segment read port for the renderer.

Parameters:
- GRID_W, 40, grid width in cells
- GRID_H, 30, grid height in cells
- COORD_W, 6, coordinate width in bits (must hold GRID_W-1 and GRID_H-1)
- MAX_LEN, 16, segment buffer depth (maximum snake length)
- INIT_LEN, 3, length after reset (2..MAX_LEN)
- PLAY_STAGE, 2, `stage` value in which movement is enabled

Ports:
- clock  in  1  system clock, all logic on its rising edge
- resetn  in  1  synchronous active-low reset
- isDrawing  in  1  frame-timing signal; the 1->0 transition marks the frame boundary
- stage  in  32  current game stage
- dir_valid  in  1  direction request strobe
- dir_req  in  2  direction: 0 up, 1 right, 2 down, 3 left
- food_x  in  COORD_W  food cell x
- food_y  in  COORD_W  food cell y
- rd_idx  in  clog2(MAX_LEN)  segment read index (0 = head)
- rd_x  out  COORD_W  segment x, registered
- rd_y  out  COORD_W  segment y, registered
- rd_active  out  1  registered: rd_idx < length
- head_x  out  COORD_W  seg[0].x
- head_y  out  COORD_W  seg[0].y
- length  out  clog2(MAX_LEN)+1  current length
- ate  out  1  one-cycle pulse when food is eaten
- step_done  out  1  one-cycle pulse after a successful step
- game_over  out  1  sticky collision flag

Behaviour:
- Reset (resetn=0 at a clock edge):
  - seg[i] = (GRID_W/2 - i, GRID_H/2) for i < INIT_LEN; other segments 0.
  - length = INIT_LEN; dir = pending_dir = right.
  - ate = step_done = game_over = 0; rd_x = rd_y = rd_active = 0; FSM = IDLE.
  - Reset wins over every other event, in any state.
- Tick:
  - isDrawing registered into isDrawing_d (reset value 0).
  - tick = isDrawing_d & ~isDrawing.
  - A tick arriving in any state other than IDLE is dropped.
- Direction:
  - dir_valid=1 latches dir_req into pending_dir, unless dir_req == dir XOR 2 (reversal); a reversal is ignored.
  - The last valid request before MOVE wins.
  - MOVE copies pending_dir into dir. A request in the same cycle as MOVE affects the next step only.
- FSM:
  - IDLE: on tick, if stage == PLAY_STAGE and game_over == 0, go to MOVE; otherwise stay (snake frozen).
  - MOVE (1 cycle):
    - Compute next = seg[0] + dir (up = y-1, down = y+1, left = x-1, right = x+1).
    - Wall hit (x==0 moving left, x==GRID_W-1 moving right, y==0 moving up, y==GRID_H-1 moving down): go to DEAD, body unchanged.
    - Otherwise shift seg[i] <= seg[i-1] for i = 1..MAX_LEN-1, and seg[0] <= next.
    - If next == (food_x, food_y): ate = 1 for this cycle, and length + 1 saturating at MAX_LEN. The pulse fires even when saturated.
    - Then go to CHECK.
  - CHECK (1 cycle):
    - Compare seg[0] against seg[1..length-1] in parallel.
    - Any match: go to DEAD.
    - No match: step_done = 1 for this cycle, go to IDLE.
  - DEAD: game_over = 1 and held; leaves only via reset.
- Latency: tick cycle -> MOVE next cycle -> CHECK next -> step_done/IDLE, i.e. 3 cycles after the tick.
- Read port:
  - rd_x, rd_y, rd_active are valid 1 cycle after rd_idx.
  - Segments at rd_idx >= length read as stored, with rd_active = 0.
- head_x, head_y, length, game_over are driven directly from registers.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- Defined: walls wrap instead of killing.
  - x = 0 moving left becomes GRID_W-1; x = GRID_W-1 moving right becomes 0.
  - Same for y with GRID_H.
  - MOVE never goes to DEAD; only a CHECK self-hit ends the game.
- Undefined: wall hit -> DEAD as specified above.

Test Plan:
- Reset, then one isDrawing 1->0 edge with stage=2 -> head moves (20,15) to (21,15), step_done pulses 3 cycles after the tick, length=3.
- stage=1 plus 5 ticks -> head stays at (20,15), no step_done. dir_valid with dir_req=3 while moving right -> ignored; next step still goes right.
- Food at (21,15), tick -> ate pulses, length=4; rd_idx=3 -> next cycle rd=(18,15), rd_active=1.
- Heading right for 20 ticks from x=20 -> head at x=39, game_over=0; tick 20 -> game_over=1; further ticks change nothing. With SNAKE_WRAP_EN: head at x=0 and game continues.
- Length 5, steer up, left, down on consecutive ticks -> the head lands on its own body, CHECK sets game_over=1, no step_done on that step.
- resetn=0 while in CHECK -> next cycle all outputs at reset values, FSM=IDLE, game_over=0.

Source files
------------

// File: rtl/snake_mover.sv
// snake_mover: per-frame snake step engine with wall/self/food detection; define SNAKE_WRAP_EN to wrap at walls
module snake_mover #(
  parameter int GRID_W = 40,
  parameter int GRID_H = 30,
  parameter int COORD_W = 6,
  parameter int MAX_LEN = 16,
  parameter int INIT_LEN = 3,
  parameter int PLAY_STAGE = 2,
  localparam int IDX_W = $clog2(MAX_LEN),
  localparam int LEN_W = IDX_W + 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               isDrawing,
  input  logic [31:0]        stage,
  input  logic               dir_valid,
  input  logic [1:0]         dir_req,
  input  logic [COORD_W-1:0] food_x,
  input  logic [COORD_W-1:0] food_y,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               rd_active,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [LEN_W-1:0]   length,
  output logic               ate,
  output logic               step_done,
  output logic               game_over
);
  typedef enum logic [1:0] {IDLE, MOVE, CHECK, DEAD} state_t;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  state_t state;
  logic [COORD_W-1:0] seg_x [MAX_LEN];
  logic [COORD_W-1:0] seg_y [MAX_LEN];
  logic [1:0] dir, pending_dir;
  logic isdrawing_d, tick, at_wall, kill, self_hit;
  logic [COORD_W-1:0] next_x, next_y;
  assign tick = isdrawing_d & ~isDrawing;
  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
`ifdef SNAKE_WRAP_EN
  assign kill = 1'b0;
`else
  assign kill = at_wall;
`endif
  // Next head cell for the step; the step adopts pending_dir, and edge cells wrap to the far side
  always_comb begin
    at_wall = (pending_dir == 2'd0) ? seg_y[0] == '0 :
              (pending_dir == 2'd1) ? seg_x[0] == X_MAX :
              (pending_dir == 2'd2) ? seg_y[0] == Y_MAX : seg_x[0] == '0;
    next_x = (pending_dir == 2'd1) ? (at_wall ? '0 : seg_x[0] + ONE) :
             (pending_dir == 2'd3) ? (at_wall ? X_MAX : seg_x[0] - ONE) : seg_x[0];
    next_y = (pending_dir == 2'd2) ? (at_wall ? '0 : seg_y[0] + ONE) :
             (pending_dir == 2'd0) ? (at_wall ? Y_MAX : seg_y[0] - ONE) : seg_y[0];
  end
  // Head against every live body segment in parallel
  always_comb begin
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      self_hit = self_hit | ((LEN_W'(i) < length) && seg_x[i] == seg_x[0] && seg_y[i] == seg_y[0]);
  end
  // Game FSM: frame tick -> MOVE -> CHECK -> IDLE, or DEAD on collision
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? COORD_W'(GRID_W / 2 - i) : '0;
        seg_y[i] <= (i < INIT_LEN) ? COORD_W'(GRID_H / 2) : '0;
      end
      length <= LEN_W'(INIT_LEN);
      dir <= 2'd1;
      pending_dir <= 2'd1;
      isdrawing_d <= 1'b0;
      ate <= 1'b0;
      step_done <= 1'b0;
      game_over <= 1'b0;
      state <= IDLE;
    end else begin
      isdrawing_d <= isDrawing;
      ate <= 1'b0;
      step_done <= 1'b0;
      if (dir_valid && dir_req != (dir ^ 2'd2)) pending_dir <= dir_req;
      case (state)
        IDLE: if (tick && stage == 32'(PLAY_STAGE) && !game_over) state <= MOVE;
        MOVE: begin
          dir <= pending_dir;
          if (kill) begin
            game_over <= 1'b1;
            state <= DEAD;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= next_x;
            seg_y[0] <= next_y;
            if (next_x == food_x && next_y == food_y) begin
              ate <= 1'b1;
              length <= (length == LEN_MAX) ? length : length + LEN_W'(1);
            end
            state <= CHECK;
          end
        end
        CHECK: begin
          game_over <= self_hit;
          step_done <= ~self_hit;
          state <= self_hit ? DEAD : IDLE;
        end
        DEAD: game_over <= 1'b1;
      endcase
    end
  end
  // Registered segment read port for the renderer
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_x <= '0;
      rd_y <= '0;
      rd_active <= 1'b0;
    end else begin
      rd_x <= seg_x[rd_idx];
      rd_y <= seg_y[rd_idx];
      rd_active <= LEN_W'(rd_idx) < length;
    end
  end
endmodule

// File: tb/tb_snake_mover.sv
// tb_snake_mover: directed and random frames checked against a queue-based snake model
module tb_snake_mover;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic isDrawing = 1'b0;
  logic [31:0] stage = 32'd2;
  logic dir_valid = 1'b0;
  logic [1:0] dir_req = 2'd0;
  logic [5:0] food_x = 6'd39, food_y = 6'd29;
  logic [3:0] rd_idx = 4'd0;
  logic [5:0] rd_x, rd_y, head_x, head_y;
  logic rd_active, ate, step_done, game_over;
  logic [4:0] length;
  int nvec = 0, nmis = 0;
  int bx[$], by[$];
  int mlen, mdir, mpend;
  bit mgo;
  int dx[4] = '{0, 1, 0, -1};
  int dy[4] = '{-1, 0, 1, 0};

  snake_mover dut (
    .clock(clock), .resetn(resetn), .isDrawing(isDrawing), .stage(stage),
    .dir_valid(dir_valid), .dir_req(dir_req), .food_x(food_x), .food_y(food_y),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_active(rd_active),
    .head_x(head_x), .head_y(head_y), .length(length), .ate(ate),
    .step_done(step_done), .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    bx = {};
    by = {};
    for (int i = 0; i < 16; i++) begin
      bx.push_back(i < 3 ? 20 - i : 0);
      by.push_back(i < 3 ? 15 : 0);
    end
    mlen = 3;
    mdir = 1;
    mpend = 1;
    mgo = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_hx"}, head_x, bx[0]);
    chk({tag, "_hy"}, head_y, by[0]);
    chk({tag, "_len"}, length, mlen);
    chk({tag, "_go"}, game_over, mgo);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    model_reset();
    check_state("rst");
    chk("rst_ate", ate, 0);
    chk("rst_sd", step_done, 0);
    chk("rst_rdx", rd_x, 0);
    chk("rst_rdy", rd_y, 0);
    chk("rst_rda", rd_active, 0);
    resetn = 1'b1;
  endtask

  task automatic request(input int d);
    dir_valid = 1'b1;
    dir_req = 2'(d);
    step();
    dir_valid = 1'b0;
    if (d != (mdir ^ 2)) mpend = d;
  endtask

  task automatic model_step(output bit es, output bit ea);
    int nx, ny;
    es = 0;
    ea = 0;
    if (stage != 2 || mgo) return;
    mdir = mpend;
    nx = bx[0] + dx[mdir];
    ny = by[0] + dy[mdir];
    if (nx < 0 || nx > 39 || ny < 0 || ny > 29) begin
`ifdef SNAKE_WRAP_EN
      nx = (nx + 40) % 40;
      ny = (ny + 30) % 30;
`else
      mgo = 1;
      return;
`endif
    end
    bx.push_front(nx);
    by.push_front(ny);
    void'(bx.pop_back());
    void'(by.pop_back());
    if (nx == food_x && ny == food_y) begin
      ea = 1;
      if (mlen < 16) mlen++;
    end
    for (int i = 1; i < mlen; i++)
      if (bx[i] == nx && by[i] == ny) mgo = 1;
    es = !mgo;
  endtask

  task automatic frame(input string tag);
    int na, ns, lat;
    bit es, ea;
    na = 0;
    ns = 0;
    lat = -1;
    isDrawing = 1'b1;
    step();
    isDrawing = 1'b0;
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      na += int'(ate);
      ns += int'(step_done);
      if (step_done && lat < 0) lat = k;
    end
    model_step(es, ea);
    check_state(tag);
    chk({tag, "_ate"}, na, ea);
    chk({tag, "_sd"}, ns, es);
    if (es) chk({tag, "_lat"}, lat, 2);
  endtask

  task automatic rd_check(input int idx);
    rd_idx = 4'(idx);
    step();
    chk("rd_x", rd_x, bx[idx]);
    chk("rd_y", rd_y, by[idx]);
    chk("rd_act", rd_active, idx < mlen);
  endtask

  task automatic food_ahead();
    int fx, fy;
    fx = bx[0] + dx[mpend];
    fy = by[0] + dy[mpend];
    food_x = 6'((fx < 0 || fx > 39) ? 39 : fx);
    food_y = 6'((fy < 0 || fy > 29) ? 29 : fy);
  endtask

  initial begin
    step();
    do_reset();
    stage = 32'd2;
    frame("first");
    stage = 32'd1;
    for (int i = 0; i < 5; i++) frame("frozen");
    stage = 32'd2;
    request(3);
    frame("reversal");
    chk("reversal_x", head_x, 22);
    food_ahead();
    frame("eat");
    chk("eat_len", length, 4);
    food_x = 6'd39;
    food_y = 6'd29;
    rd_check(3);
    rd_check(4);
    rd_check(0);
    do_reset();
    for (int i = 0; i < 19; i++) frame("run");
    chk("edge_x", head_x, 39);
    chk("edge_go", game_over, 0);
    for (int i = 0; i < 3; i++) frame("wall");
`ifndef SNAKE_WRAP_EN
    chk("wall_go", game_over, 1);
`endif
    do_reset();
    food_ahead();
    frame("grow1");
    food_ahead();
    frame("grow2");
    food_x = 6'd39;
    food_y = 6'd29;
    request(0);
    frame("up");
    request(3);
    frame("left");
    request(2);
    frame("down");
    chk("selfhit_go", game_over, 1);
    frame("dead");
    do_reset();
    isDrawing = 1'b1;
    step();
    isDrawing = 1'b0;
    step();
    step();
    resetn = 1'b0;
    step();
    model_reset();
    check_state("rstchk");
    chk("rstchk_sd", step_done, 0);
    chk("rstchk_ate", ate, 0);
    chk("rstchk_rda", rd_active, 0);
    resetn = 1'b1;
    frame("after_rst");
    for (int f = 0; f < 200; f++) begin
      stage = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd2;
      for (int r = $urandom_range(0, 2); r > 0; r--) request($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) food_ahead();
      else begin
        food_x = 6'($urandom_range(0, 39));
        food_y = 6'($urandom_range(0, 29));
      end
      frame("rand");
      rd_check($urandom_range(0, 15));
      if (mgo && $urandom_range(0, 2) == 0) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
